instr_fetch_issue: RTL
======================

Name: instr_fetch_issue

Overview:
Fetch stage directly upstream of the opcode decoder. Maintains the PC and fetches 32-bit instructions over a req/ack instruction-memory handshake. It latches each word into an instruction register and presents the decoder's 6-bit selector field with a one-hot-safe enable. It also resolves the R-type funct/opcode aliasing by flagging R-type words, and handles branch/jump redirects, fetch timeouts and misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned
ACK_TIMEOUT, 255, max cycles in REQ without imem_ack before FAULT; 0 disables timeout
TO_W, 8, width of timeout counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  fetch address (= pc); stable while imem_req high
imem_ack  in  1  memory returns imem_rdata this cycle; may arrive in the same cycle as req
imem_rdata  in  32  instruction word, valid only when imem_ack=1
redirect_valid  in  1  one-cycle pulse: load redirect_pc as next fetch PC
redirect_pc  in  32  branch/jump target
issue_ready  in  1  decoder/control accepts the current instruction
dec_enable  out  1  drives decoder Enable; high only while a valid instruction is issued
dec_field  out  6  decoder select: funct ir[5:0] if R-type, else opcode ir[31:26]
is_rtype  out  1  ir[31:26]==6'b000000
ir  out  32  latched instruction
pc_out  out  32  PC of the latched instruction
fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (sync, active-high, clk rising edge): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir=0, pc_out=0, dec_field=0, dec_enable=0, is_rtype=0, fetch_fault=0, timeout counter=0, squash=0.
- States: IDLE, REQ, ISSUE, FAULT. All outputs are registered or derived from registered state only; no combinational path from inputs to outputs.
- IDLE: goes to REQ the next cycle. An imem_ack received in IDLE is ignored, including a late ack from a transaction interrupted by reset.
- REQ: imem_req=1, imem_addr=pc. Counter increments each cycle without ack.
  - On ack with squash=0: ir<=imem_rdata, pc_out<=pc, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), counter<=0, go to ISSUE.
  - On ack with squash=1: discard data, squash<=0, stay in REQ at the new pc. This costs one cycle with imem_req=0.
- ISSUE: dec_enable=1; dec_field and is_rtype are derived from ir. The state holds with all outputs stable until issue_ready=1, then goes to REQ the next cycle.
- Latency: ack at cycle N gives dec_enable=1 at cycle N+1. With zero-wait memory and issue_ready tied high, the peak rate is 1 instruction per 2 cycles.
- Redirect (priority over normal sequencing):
  - In REQ without ack: the bus transaction cannot be aborted. pc<=redirect_pc, squash<=1, imem_addr unchanged until ack.
  - In REQ with ack in the same cycle: data discarded, pc<=redirect_pc, REQ restarts next cycle.
  - In ISSUE: dec_enable drops next cycle, pc<=redirect_pc, go to REQ. If issue_ready is also high that cycle, the instruction counts as consumed.
  - In IDLE: pc<=redirect_pc.
  - In FAULT: ignored.
- Misaligned redirect (redirect_pc[1:0]!=0): go to FAULT.
- Timeout: counter reaching ACK_TIMEOUT while in REQ goes to FAULT.
- FAULT: fetch_fault=1, imem_req=0, dec_enable=0, ir and pc_out hold. Exit only via rst.
- dec_enable=0 in every state except ISSUE. The decoder therefore never sees a stale field as valid.

Decomposition:
- Shared package mips_pkg holds:
  - OPC_RTYPE=6'b000000
  - field index constants OPC_MSB=31, OPC_LSB=26, FUNCT_MSB=5, FUNCT_LSB=0
  - fetch_state_t enum {IDLE, REQ, ISSUE, FAULT}
  - WORD_BYTES=4
- Single module; no sub-module is warranted. The funct/opcode select is a single mux inside this block.

Test Plan:
- Reset, zero-wait memory returning 32'h0232_8020 (ADD) at 0 and 32'h2108_0005 (ADDI) at 4, issue_ready=1 -> first: dec_field=6'b100000 and is_rtype=1 with pc_out=0; then dec_field=6'b001000 and is_rtype=0 with pc_out=4; dec_enable high one cycle every 2 cycles.
- imem_ack delayed 3 cycles, issue_ready low 4 cycles in ISSUE -> imem_req/imem_addr stable through the wait; dec_enable, ir and dec_field stable through the stall; no PC advance.
- redirect_pc=32'h0000_0100 pulsed in REQ 1 cycle before ack -> returned word discarded, dec_enable stays 0, next imem_addr=32'h100.
- Redirect and issue_ready in the same ISSUE cycle -> next fetch at redirect_pc, not pc+4. Misaligned redirect_pc=32'h0000_0102 -> fetch_fault=1, imem_req=0 permanently until rst.
- ACK_TIMEOUT=4, no ack -> fetch_fault asserted after 4 REQ cycles. Assert rst mid-REQ -> imem_req=0 and pc=RESET_PC next cycle; a late ack is ignored.
- pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction field positions,
// the fetch FSM state type and the decoder field select helper.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // R-type words share opcode 0, so the decoder must see funct instead.
  function automatic logic is_rtype_word(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_RTYPE;
  endfunction

  // Single mux resolving the funct/opcode aliasing for the decoder select.
  function automatic logic [5:0] select_field(input logic [31:0] word);
    return is_rtype_word(word) ? word[FUNCT_MSB:FUNCT_LSB] : word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_issue.sv
// Fetch stage feeding the opcode decoder. Keeps the PC, fetches words over a
// req/ack handshake, latches them into the instruction register and issues
// them to the decoder with a registered enable. Handles redirects (with a
// squash for transactions that cannot be aborted), ack timeouts and
// misaligned targets, the latter two ending in a sticky fault.
module instr_fetch_issue
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        issue_ready,
  output logic        dec_enable,
  output logic [5:0]  dec_field,
  output logic        is_rtype,
  output logic [31:0] ir,
  output logic [31:0] pc_out,
  output logic        fetch_fault
);

  fetch_state_t    state, state_d;
  logic [31:0]     pc, pc_d;
  logic [TO_W-1:0] to_cnt, cnt_d;
  logic            squash, squash_d;

  logic            req_d;
  logic [31:0]     addr_d;
  logic [31:0]     ir_d;
  logic [31:0]     pc_out_d;
  logic [5:0]      field_d;
  logic            rtype_d;
  logic            en_d;
  logic            fault_d;

  logic            ack_valid;
  logic            redirect_bad;
  logic            timeout_hit;
  logic            enter_fault;
  logic [TO_W-1:0] cnt_inc;
  logic [31:0]     pc_inc;

  // An ack only means something while our request is actually on the bus.
  assign ack_valid    = imem_ack && imem_req;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign cnt_inc      = to_cnt + TO_W'(1);
  assign pc_inc       = pc + 32'(WORD_BYTES);
  // ACK_TIMEOUT of zero turns the watchdog off; the counter is sized by TO_W.
  assign timeout_hit  = (ACK_TIMEOUT != 0) && (cnt_inc == TO_W'(ACK_TIMEOUT));

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    cnt_d       = to_cnt;
    squash_d    = squash;
    req_d       = imem_req;
    addr_d      = imem_addr;
    ir_d        = ir;
    pc_out_d    = pc_out;
    field_d     = dec_field;
    rtype_d     = is_rtype;
    en_d        = dec_enable;
    fault_d     = fetch_fault;
    enter_fault = 1'b0;

    if (state != FAULT && redirect_bad) begin
      enter_fault = 1'b1;
    end

    unique case (state)
      IDLE: begin
        // Any ack seen here belongs to a transaction we no longer own.
        cnt_d   = '0;
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc;
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          addr_d = redirect_pc;
        end
      end

      REQ: begin
        if (ack_valid) begin
          cnt_d = '0;
          if (squash) begin
            // Stale word from before a redirect: drop it and take a bubble
            // so the new address is presented cleanly.
            squash_d = 1'b0;
            req_d    = 1'b0;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else if (redirect_valid) begin
            // Word arrived alongside a redirect: discard and restart at target.
            pc_d   = redirect_pc;
            req_d  = 1'b1;
            addr_d = redirect_pc;
          end else begin
            ir_d     = imem_rdata;
            pc_out_d = pc;
            pc_d     = pc_inc;
            field_d  = select_field(imem_rdata);
            rtype_d  = is_rtype_word(imem_rdata);
            req_d    = 1'b0;
            en_d     = 1'b1;
            state_d  = ISSUE;
          end
        end else if (!imem_req) begin
          // Post-squash bubble: launch the request at the current PC.
          cnt_d  = '0;
          req_d  = 1'b1;
          addr_d = pc;
          if (redirect_valid) begin
            pc_d   = redirect_pc;
            addr_d = redirect_pc;
          end
        end else if (timeout_hit) begin
          enter_fault = 1'b1;
        end else begin
          // Outstanding bus transaction cannot be aborted; remember to drop it.
          cnt_d = cnt_inc;
          if (redirect_valid) begin
            pc_d     = redirect_pc;
            squash_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (redirect_valid || issue_ready) begin
          state_d = REQ;
          en_d    = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc;
          if (redirect_valid) begin
            pc_d   = redirect_pc;
            addr_d = redirect_pc;
          end
        end
      end

      FAULT: begin
        req_d = 1'b0;
        en_d  = 1'b0;
      end
    endcase

    if (enter_fault) begin
      state_d  = FAULT;
      pc_d     = pc;
      cnt_d    = '0;
      squash_d = 1'b0;
      req_d    = 1'b0;
      en_d     = 1'b0;
      fault_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      to_cnt      <= '0;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      ir          <= '0;
      pc_out      <= '0;
      dec_field   <= '0;
      is_rtype    <= 1'b0;
      dec_enable  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      to_cnt      <= cnt_d;
      squash      <= squash_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      ir          <= ir_d;
      pc_out      <= pc_out_d;
      dec_field   <= field_d;
      is_rtype    <= rtype_d;
      dec_enable  <= en_d;
      fetch_fault <= fault_d;
    end
  end

endmodule
